// File: rtl/xup_prbs_pkg.sv
// Shared definitions for the XUP PRBS generator/checker pair: state encoding and
// default XNOR-LFSR tap masks so both ends of a link agree on the polynomial.
package xup_prbs_pkg;

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    localparam logic [7:0]  TAPS_SIZE8  = 8'hB8;
    localparam logic [15:0] TAPS_SIZE16 = 16'hB400;

    // Maximal-length XNOR tap masks; bit i set means stage i feeds back.
    function automatic logic [31:0] default_taps(input int unsigned size);
        logic [31:0] taps;
        case (size)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = {24'h0, TAPS_SIZE8};
            16:      taps = {16'h0, TAPS_SIZE16};
            32:      taps = 32'h8020_0003;
            default: taps = {24'h0, TAPS_SIZE8};
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/xup_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module xup_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/xup_prbs_checker.sv
// Serial XNOR-LFSR PRBS checker: self-seeds in SYNC, flywheels once LOCKED.
// Optional bit_count output is enabled by defining XUP_PRBS_CHK_BITCNT_EN.
module xup_prbs_checker
    import xup_prbs_pkg::*;
#(
    parameter int unsigned     SIZE        = 8,
    parameter logic [SIZE-1:0] TAPS        = SIZE'(default_taps(SIZE)),
    parameter int unsigned     LOCK_THRESH = 16,
    parameter int unsigned     LOSS_THRESH = 4,
    parameter int unsigned     ERR_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rx_data,
    input  logic             rx_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
`ifdef XUP_PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);

    prbs_state_e        state_q;
    logic [SIZE-1:0]    shreg_q;
    logic [SIZE-1:0]    shreg_d;
    logic [MATCH_W-1:0] match_run_q;
    logic [MISS_W-1:0]  miss_run_q;
    logic               locked_q;
    logic               err_pulse_q;

    logic pred;
    logic mis;
    logic err_inc;

    assign pred    = ~^(shreg_q & TAPS);
    assign mis     = rx_data ^ pred;
    assign err_inc = rx_valid && (state_q == LOCKED) && mis;

    // In LOCKED the register shifts in its own prediction so line errors cannot corrupt it.
    always_comb begin
        shreg_d = shreg_q;
        if (rx_valid) begin
            if (state_q == SYNC) begin
                shreg_d = {shreg_q[SIZE-2:0], rx_data};
            end else begin
                shreg_d = {shreg_q[SIZE-2:0], pred};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= SYNC;
            shreg_q     <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            shreg_q     <= shreg_d;
            if (rx_valid) begin
                case (state_q)
                    SYNC: begin
                        if (mis) begin
                            match_run_q <= '0;
                        end else if (match_run_q + MATCH_W'(1) == MATCH_W'(LOCK_THRESH)) begin
                            state_q     <= LOCKED;
                            locked_q    <= 1'b1;
                            match_run_q <= '0;
                            miss_run_q  <= '0;
                        end else begin
                            match_run_q <= match_run_q + MATCH_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (mis) begin
                            err_pulse_q <= 1'b1;
                            if (miss_run_q + MISS_W'(1) == MISS_W'(LOSS_THRESH)) begin
                                state_q     <= SYNC;
                                locked_q    <= 1'b0;
                                match_run_q <= '0;
                                miss_run_q  <= '0;
                            end else begin
                                miss_run_q <= miss_run_q + MISS_W'(1);
                            end
                        end else begin
                            miss_run_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= SYNC;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

    xup_sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (err_clr),
        .inc    (err_inc),
        .count  (err_count)
    );

`ifdef XUP_PRBS_CHK_BITCNT_EN
    xup_sat_counter #(
        .WIDTH (32)
    ) u_bit_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (err_clr),
        .inc    (rx_valid && (state_q == LOCKED)),
        .count  (bit_count)
    );
`endif

endmodule

// File: tb/tb_xup_prbs_checker.sv
// Directed bench for xup_prbs_checker: a 16-bit-count and a 4-bit-count instance
// share one stimulus stream from an XNOR LFSR model seeded with 0.
module tb_xup_prbs_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_data;
    logic        rx_valid;
    logic        err_clr;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;

    logic [7:0]  gen_q;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    xup_prbs_checker #(
        .SIZE(8), .TAPS(8'hB8), .LOCK_THRESH(16), .LOSS_THRESH(4), .ERR_W(16)
    ) u_dut (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    xup_prbs_checker #(
        .SIZE(8), .TAPS(8'hB8), .LOCK_THRESH(16), .LOSS_THRESH(4), .ERR_W(4)
    ) u_dut4 (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .err_clr(err_clr), .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; the model advances only on valid bits outside reset.
    task automatic step(input logic vld, input logic flip, input logic clr);
        logic gen_bit;
        gen_bit  = ~^(gen_q & 8'hB8);
        rx_data  = gen_bit ^ flip;
        rx_valid = vld;
        err_clr  = clr;
        @(posedge clk);
        #1;
        if (vld && resetn) gen_q = {gen_q[6:0], gen_bit};
    endtask

    initial begin
        int  n;
        int  nv;
        int  seen;
        logic v;

        resetn   = 1'b0;
        rx_data  = 1'b0;
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        gen_q    = 8'h00;

        // 1: reset with random line activity
        for (int i = 0; i < 6; i++) begin
            rx_data  = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_locked", {31'b0, locked}, 32'd0);
            check("rst_pulse", {31'b0, err_pulse}, 32'd0);
            check("rst_count", {16'b0, err_count}, 32'd0);
        end
        $display("txn reset: locked=%0d err_count=%0d", locked, err_count);
        resetn = 1'b1;
        gen_q  = 8'h00;

        // 2: clean stream locks on the 16th valid bit, then stays clean
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        check("lock_not_yet_15", {31'b0, locked}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("lock_at_16", {31'b0, locked}, 32'd1);
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (err_pulse || !locked) seen++;
        end
        check("clean_1000_events", seen, 32'd0);
        check("clean_1000_count", {16'b0, err_count}, 32'd0);
        $display("txn clean: locked=%0d err_count=%0d", locked, err_count);

        // 3: single flipped bit while locked; idle flipped bit is ignored
        step(1'b1, 1'b1, 1'b0);
        check("single_pulse", {31'b0, err_pulse}, 32'd1);
        check("single_count", {16'b0, err_count}, 32'd1);
        check("single_locked", {31'b0, locked}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("idle_no_pulse", {31'b0, err_pulse}, 32'd0);
        check("idle_count_hold", {16'b0, err_count}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("single_pulse_once", {31'b0, err_pulse}, 32'd0);
        $display("txn single_err: err_count=%0d locked=%0d", err_count, locked);

        // 4: four consecutive errors drop lock, then relock
        step(1'b1, 1'b0, 1'b1);
        check("clr_count", {16'b0, err_count}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        check("burst3_locked", {31'b0, locked}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("burst4_unlocked", {31'b0, locked}, 32'd0);
        check("burst4_count", {16'b0, err_count}, 32'd4);
        check("burst4_pulse", {31'b0, err_pulse}, 32'd1);
        n = 0;
        for (int i = 0; i < 24 && !locked; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("relock_locked", {31'b0, locked}, 32'd1);
        check("relock_bits", n, 32'd16);
        check("relock_count_kept", {16'b0, err_count}, 32'd4);
        check("relock_count4_kept", {28'b0, err_count4}, 32'd4);
        $display("txn burst: relock_bits=%0d err_count=%0d", n, err_count);

        // 5: every 10th bit flipped, 20 errors; 4-bit counter saturates
        step(1'b1, 1'b0, 1'b1);
        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        check("sat_count4", {28'b0, err_count4}, 32'd15);
        check("sat_count16", {16'b0, err_count}, 32'd20);
        check("sat_locked", {31'b0, locked}, 32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("clr_wins_count4", {28'b0, err_count4}, 32'd0);
        check("clr_wins_count16", {16'b0, err_count}, 32'd0);
        check("clr_wins_pulse", {31'b0, err_pulse4}, 32'd1);
        $display("txn saturate: err_count4 after clr=%0d pulse=%0d", err_count4, err_pulse4);

        // 6: mid-stream reset, then 50% rx_valid on a clean stream
        resetn = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check("midrst_locked", {31'b0, locked}, 32'd0);
        check("midrst_count", {16'b0, err_count}, 32'd0);
        resetn = 1'b1;
        gen_q  = 8'h00;
        nv     = 0;
        for (int i = 0; i < 300 && nv < 16; i++) begin
            v = 1'($urandom_range(0, 1));
            step(v, v ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
            if (v) nv++;
            check("gap_locked", {31'b0, locked}, (nv >= 16) ? 32'd1 : 32'd0);
            check("gap_pulse", {31'b0, err_pulse}, 32'd0);
        end
        check("gap_valid_bits", nv, 32'd16);
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            step(v, v ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
        end
        check("gap_final_locked", {31'b0, locked}, 32'd1);
        check("gap_final_count", {16'b0, err_count}, 32'd0);
        $display("txn gapped: valid_bits=%0d locked=%0d err_count=%0d", nv, locked, err_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xup_prbs_checker.md
# xup_prbs_checker

Serial PRBS checker: the receive end of the XNOR-feedback LFSR pattern generator in the XUP library. It synchronises to an incoming bit stream and then flywheels its own LFSR. Each received bit is compared against the predicted bit; the block reports lock status, per-bit error pulses and a saturating error count. It sits after a deserialiser or loopback path on Basys3 link tests.

## Interface
- SIZE, 8: LFSR length in bits, 3..32.
- TAPS, 8'hB8: feedback tap mask, SIZE bits wide; bit i set means stage i is tapped.
- LOCK_THRESH, 16: consecutive matches in SYNC required to lock.
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that drop lock.
- ERR_W, 16: error counter width.
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- rx_data  in  1  received bit.
- rx_valid  in  1  rx_data qualifier; the block acts only when this is high.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  ERR_W  saturating count of mismatches detected in LOCKED.

## Operation
- Predicted bit: pred = ~^(shreg & TAPS). This is XNOR feedback, identical to the generator.
- All-ones is the XNOR lockup pattern and never occurs in a valid stream.
- Reset values: shreg=0, state=SYNC, run counters=0, locked=0, err_pulse=0, err_count=0.
- Mismatch: mis = rx_data ^ pred, evaluated only when rx_valid=1.
- With rx_valid=0, all state holds and err_pulse=0.
- SYNC state:
  - shreg <= {shreg[SIZE-2:0], rx_data}, so the register self-seeds from the line.
  - match_run increments on !mis and clears on mis.
  - When a valid match brings match_run to LOCK_THRESH: go to LOCKED, clear match_run and miss_run.
- LOCKED state (flywheel):
  - shreg <= {shreg[SIZE-2:0], pred}, so line errors never corrupt the prediction.
  - On mis: err_pulse=1, err_count increments (saturating at 2^ERR_W-1), miss_run increments.
  - On !mis: miss_run clears.
  - When miss_run reaches LOSS_THRESH: go to SYNC, clear both run counters. Mismatches counted before the loss stay counted.
- Mismatches detected in SYNC never pulse err_pulse and never count.
- err_clr:
  - Clears err_count to 0 in any state.
  - If a mismatch occurs in the same cycle, clear wins and the count stays 0.
  - err_pulse still asserts for that mismatch.
- A reset asserted mid-stream returns every register to its reset value on that edge, regardless of state.

## Timing
- All outputs are registered.
- err_pulse is high on the cycle after the edge that sampled the failing bit.
- locked rises on the edge that samples the LOCK_THRESH-th consecutive valid match.
- locked falls on the edge that samples the LOSS_THRESH-th consecutive valid mismatch.
- Minimum relock after loss: LOCK_THRESH valid bits if shreg already holds correct history; SIZE+LOCK_THRESH valid bits in general.
- err_count updates on the same edge as err_pulse.
- Throughput: one bit per clock; no back-pressure.

## Configuration
- XUP_PRBS_CHK_BITCNT_EN defined:
  - Adds output bit_count [31:0]: valid bits checked while LOCKED, saturating at 2^32-1.
  - err_clr also clears bit_count.
  - BER = err_count / bit_count.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package xup_prbs_pkg holds:
  - state encoding constants (SYNC, LOCKED);
  - default tap masks per SIZE, for example 8'hB8 for SIZE=8 and 16'hB400 for SIZE=16.
- The generator uses the same package, so both ends agree on the polynomial.
- One sub-module: xup_sat_counter (parameter width; ports clk, resetn, clr, inc, count). Used for err_count, and for bit_count when enabled.

## Test plan
All scenarios use SIZE=8, TAPS=8'hB8, LOCK_THRESH=16, LOSS_THRESH=4. The bench generator is an XNOR LFSR seeded with 0.
1. Reset: hold resetn=0 with random rx_data and rx_valid -> locked=0, err_pulse=0, err_count=0 throughout.
2. Clean stream, rx_valid=1 -> locked=1 after the edge sampling valid bit 16; over 1000 further bits err_count=0 and err_pulse never fires.
3. Flip bit 200 while locked -> exactly one err_pulse on the next cycle; err_count=1; locked stays 1.
4. Flip 4 consecutive bits -> err_count=4 and locked=0 after the 4th; with a clean stream, relock within 24 valid bits; err_count remains 4.
5. ERR_W=4, flip every 10th bit for 20 errors -> err_count saturates at 15. Assert err_clr on a cycle with a flipped bit -> err_count=0 and err_pulse=1.
6. Toggle rx_valid randomly at 50% on a clean stream -> lock after 16 valid bits; no errors. Idle cycles change nothing, including run counters.
